apb_decode_n: RTL and testbench

APB_DECODE_N -- requirements
Module: apb_decode_n

---
 rtl/apb_decode_n_pkg.sv | 33 +++
 rtl/apb_decode_n_addr_decode.sv | 36 +++
 rtl/apb_decode_n.sv | 138 +++++++++++++
 tb/tb_apb_decode_n.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_decode_n_pkg.sv
// Shared types and default address map for the APB 1-to-N decoder.
package apbDecode_package;

    localparam int DEF_NUM_TGT = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;

    typedef logic [DEF_ADDR_W-1:0] apbAddrSt;
    typedef logic [DEF_DATA_W-1:0] apbDataSt;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_e;

    // Target index width; a single-target build still needs one bit.
    function automatic int tgt_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [tgt_idx_w(DEF_NUM_TGT)-1:0] tgt_idx_t;

    localparam logic [DEF_NUM_TGT*DEF_ADDR_W-1:0] DEF_TGT_BASE = {
        apbAddrSt'(32'h0000_3000), apbAddrSt'(32'h0000_2000),
        apbAddrSt'(32'h0000_1000), apbAddrSt'(32'h0000_0000)
    };

    localparam logic [DEF_NUM_TGT*DEF_ADDR_W-1:0] DEF_TGT_MASK =
        {DEF_NUM_TGT{apbAddrSt'(32'hFFFF_F000)}};

endpackage

// File: rtl/apb_decode_n_addr_decode.sv
// Combinational base/mask address match; the lowest matching target index wins.
module apb_addr_decode
    import apbDecode_package::*;
#(
    parameter int NUM_TGT = DEF_NUM_TGT,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE = DEF_TGT_BASE,
    parameter logic [NUM_TGT*ADDR_W-1:0] TGT_MASK = DEF_TGT_MASK,
    localparam int IDX_W = tgt_idx_w(NUM_TGT)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);

    logic [NUM_TGT-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TGT; gi++) begin : g_match
            assign match[gi] = (addr & TGT_MASK[gi*ADDR_W +: ADDR_W]) == TGT_BASE[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    // Scan from the top down so the lowest index is the last one written.
    always_comb begin
        hit = |match;
        idx = '0;
        for (int i = NUM_TGT - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/apb_decode_n.sv
// APB 1-to-N decoder bridge: one upstream completer port fanned out to NUM_TGT completers.
// Optional ACCESS timeout is enabled by defining APB_DECODE_TIMEOUT_EN.
module apb_decode_n
    import apbDecode_package::*;
#(
    parameter int NUM_TGT     = DEF_NUM_TGT,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter logic [NUM_TGT*ADDR_W-1:0] TGT_BASE = DEF_TGT_BASE,
    parameter logic [NUM_TGT*ADDR_W-1:0] TGT_MASK = DEF_TGT_MASK,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_psel,
    input  logic                      s_penable,
    input  logic                      s_pwrite,
    input  logic [ADDR_W-1:0]         s_paddr,
    input  logic [DATA_W-1:0]         s_pwdata,
    output logic                      s_pready,
    output logic                      s_pslverr,
    output logic [DATA_W-1:0]         s_prdata,
    output logic [NUM_TGT-1:0]        m_psel,
    output logic                      m_penable,
    output logic                      m_pwrite,
    output logic [ADDR_W-1:0]         m_paddr,
    output logic [DATA_W-1:0]         m_pwdata,
    input  logic [NUM_TGT-1:0]        m_pready,
    input  logic [NUM_TGT-1:0]        m_pslverr,
    input  logic [NUM_TGT*DATA_W-1:0] m_prdata
);

    localparam int IDX_W = tgt_idx_w(NUM_TGT);

    if (NUM_TGT < 1 || NUM_TGT > 16 || (DATA_W % 8) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("apb_decode_n: illegal parameter value");
    end

    apb_state_e       state_reg;
    logic             hit_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             dec_hit;
    logic [IDX_W-1:0] dec_idx;

`ifdef APB_DECODE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_reg;
`endif

    apb_addr_decode #(
        .NUM_TGT  (NUM_TGT),
        .ADDR_W   (ADDR_W),
        .TGT_BASE (TGT_BASE),
        .TGT_MASK (TGT_MASK)
    ) u_decode (
        .addr (s_paddr),
        .hit  (dec_hit),
        .idx  (dec_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            hit_reg   <= 1'b0;
            idx_reg   <= '0;
            s_pready  <= 1'b0;
            s_pslverr <= 1'b0;
            s_prdata  <= '0;
            m_psel    <= '0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
`ifdef APB_DECODE_TIMEOUT_EN
            cnt_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    // Only an upstream SETUP phase starts a transfer; stray ACCESS phases are ignored.
                    if (s_psel && !s_penable) begin
                        m_paddr   <= s_paddr;
                        m_pwdata  <= s_pwdata;
                        m_pwrite  <= s_pwrite;
                        hit_reg   <= dec_hit;
                        idx_reg   <= dec_idx;
                        m_psel    <= dec_hit ? (NUM_TGT'(1) << dec_idx) : '0;
                        state_reg <= SETUP;
                    end
                end
                SETUP: begin
                    if (hit_reg) begin
                        m_penable <= 1'b1;
                        state_reg <= ACCESS;
`ifdef APB_DECODE_TIMEOUT_EN
                        cnt_reg   <= '0;
`endif
                    end else begin
                        s_pready  <= 1'b1;
                        s_pslverr <= 1'b1;
                        s_prdata  <= '0;
                        state_reg <= RESP;
                    end
                end
                ACCESS: begin
                    if (m_pready[idx_reg]) begin
                        m_psel    <= '0;
                        m_penable <= 1'b0;
                        s_pready  <= 1'b1;
                        s_pslverr <= m_pslverr[idx_reg];
                        s_prdata  <= m_pwrite ? '0 : m_prdata[idx_reg*DATA_W +: DATA_W];
                        state_reg <= RESP;
                    end
`ifdef APB_DECODE_TIMEOUT_EN
                    else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
                        m_psel    <= '0;
                        m_penable <= 1'b0;
                        s_pready  <= 1'b1;
                        s_pslverr <= 1'b1;
                        s_prdata  <= '0;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`endif
                end
                RESP: begin
                    s_pready  <= 1'b0;
                    s_pslverr <= 1'b0;
                    s_prdata  <= '0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_decode_n.sv
// Randomized bench for apb_decode_n: expected outputs are laid out per cycle from transaction timing rules.
`timescale 1ns/1ps
module tb_apb_decode_n;

    localparam int NT = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO_CYC = 8;
`ifdef APB_DECODE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    // Overlapping map: target 2 also covers 0x0xxx, and 0x2xxx reaches only target 2.
    localparam logic [NT*AW-1:0] BASE = {32'h0000_3000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [NT*AW-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_D000, 32'hFFFF_F000, 32'hFFFF_F000};

    logic [31:0] base_a [NT] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_0000, 32'h0000_3000};
    logic [31:0] mask_a [NT] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_D000, 32'hFFFF_F000};

    logic           clk = 1'b0;
    logic           rst;
    logic           s_psel, s_penable, s_pwrite;
    logic [AW-1:0]  s_paddr;
    logic [DW-1:0]  s_pwdata;
    logic           s_pready, s_pslverr;
    logic [DW-1:0]  s_prdata;
    logic [NT-1:0]  m_psel;
    logic           m_penable, m_pwrite;
    logic [AW-1:0]  m_paddr;
    logic [DW-1:0]  m_pwdata;
    logic [NT-1:0]  m_pready, m_pslverr;
    logic [NT*DW-1:0] m_prdata;

    apb_decode_n #(
        .NUM_TGT(NT), .ADDR_W(AW), .DATA_W(DW),
        .TGT_BASE(BASE), .TGT_MASK(MASK), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata),
        .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit [3:0]  psel;
        bit        penable;
        bit        pready;
        bit        pslverr;
        bit [31:0] prdata;
        bit        bus_chk;
        bit [31:0] paddr;
        bit [31:0] pwdata;
        bit        pwrite;
    } exp_t;

    exp_t exp_q [16384];
    exp_t ec;

    int n_chk = 0;
    int n_fail = 0;
    int resp_cyc;
    logic [31:0] resp_data;
    logic resp_err;
    logic [3:0] psel_seen;
    int psel_cycles;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, req);
        end
    endtask

    // Per-cycle comparison against the expectation table.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < 16384) begin
            ec = exp_q[cyc];
            chk("m_psel", {28'b0, m_psel}, {28'b0, ec.psel});
            chk("m_penable", {31'b0, m_penable}, {31'b0, ec.penable});
            chk("s_pready", {31'b0, s_pready}, {31'b0, ec.pready});
            chk("s_pslverr", {31'b0, s_pslverr}, {31'b0, ec.pslverr});
            chk("s_prdata", s_prdata, ec.prdata);
            if (ec.bus_chk) begin
                chk("m_paddr", m_paddr, ec.paddr);
                chk("m_pwdata", m_pwdata, ec.pwdata);
                chk("m_pwrite", {31'b0, m_pwrite}, {31'b0, ec.pwrite});
            end
            if (s_pready === 1'b1) begin
                resp_cyc  = cyc;
                resp_data = s_prdata;
                resp_err  = s_pslverr;
            end
            psel_seen = psel_seen | m_psel;
            if (m_psel != 4'b0) psel_cycles++;
        end
    end

    function automatic void model_decode(input logic [31:0] a, output bit hit, output int tgt);
        hit = 1'b0;
        tgt = 0;
        for (int i = NT - 1; i >= 0; i--) begin
            if ((a & mask_a[i]) == base_a[i]) begin
                hit = 1'b1;
                tgt = i;
            end
        end
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
        s_pwrite = 1'($urandom); s_paddr = $urandom; s_pwdata = $urandom;
        m_pready = 4'($urandom); m_pslverr = 4'($urandom);
        m_prdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_idle();
            next_cycle();
        end
    endtask

    task automatic do_reset(input int n);
        int c0;
        c0 = cyc;
        for (int c = c0 + 1; c <= c0 + n; c++) begin
            exp_q[c] = '{default: 0};
            exp_q[c].bus_chk = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            drive_idle();
            rst = 1'b1;
            next_cycle();
        end
        rst = 1'b0;
    endtask

    task automatic clear_obs();
        resp_cyc = -1; resp_data = '0; resp_err = 1'b0;
        psel_seen = '0; psel_cycles = 0;
    endtask

    // One upstream transfer starting in the current cycle; w = wait cycles before target is ready.
    task automatic do_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                           input int w, input logic [31:0] rdata, input bit err,
                           input bit drop, input int abort_at);
        int t0, tr, last, tgt;
        bit hit, tmo;
        t0 = cyc;
        model_decode(addr, hit, tgt);
        tmo = TO_EN && hit && (w >= TO_CYC);
        if (!hit)     tr = t0 + 2;
        else if (tmo) tr = t0 + 2 + TO_CYC;
        else          tr = t0 + 3 + w;
        if (hit) begin
            for (int c = t0 + 1; c < tr; c++) begin
                exp_q[c].psel    = 4'(1 << tgt);
                exp_q[c].penable = (c >= t0 + 2);
                exp_q[c].bus_chk = 1'b1;
                exp_q[c].paddr   = addr;
                exp_q[c].pwdata  = wdata;
                exp_q[c].pwrite  = wr;
            end
        end
        exp_q[tr].pready  = 1'b1;
        exp_q[tr].pslverr = !hit || tmo || err;
        exp_q[tr].prdata  = (hit && !tmo && !wr) ? rdata : 32'h0;
        last = tr;
        if (abort_at >= 0) begin
            last = t0 + abort_at;
            for (int c = last + 1; c <= tr; c++) begin
                exp_q[c] = '{default: 0};
                exp_q[c].bus_chk = (c == last + 1);
            end
        end
        for (int c = t0; c <= last; c++) begin
            rst       = (abort_at >= 0) && (c == last);
            s_psel    = !(drop && c >= t0 + 2);
            s_penable = s_psel && (c > t0);
            s_pwrite  = wr; s_paddr = addr; s_pwdata = wdata;
            m_pready  = 4'($urandom); m_pslverr = 4'($urandom);
            m_prdata  = {$urandom, $urandom, $urandom, $urandom};
            if (hit) begin
                m_pready[tgt]  = !tmo && (c == t0 + 2 + w);
                m_pslverr[tgt] = err;
                m_prdata[tgt*32 +: 32] = rdata;
            end
            next_cycle();
        end
        rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    endtask

    initial begin
        int t0;
        int w;
        logic [31:0] a;
        drive_idle();
        clear_obs();
        do_reset(3);
        idle(2);

        // Read to target 1, ready on first ACCESS cycle.
        clear_obs(); t0 = cyc;
        do_xfer(32'h0000_1004, 1'b0, 32'h0, 0, 32'hA5A5_0001, 1'b0, 1'b0, -1);
        chk("rd1_latency", 32'(resp_cyc - t0), 32'd3);
        chk("rd1_rdata", resp_data, 32'hA5A5_0001);
        chk("rd1_err", {31'b0, resp_err}, 32'd0);
        chk("rd1_psel_seen", {28'b0, psel_seen}, 32'h2);
        idle(1);

        // Write to target 3 with 5 wait cycles.
        clear_obs(); t0 = cyc;
        do_xfer(32'h0000_3010, 1'b1, 32'hDEAD_BEEF, 5, 32'h1111_2222, 1'b0, 1'b0, -1);
        chk("wr3_latency", 32'(resp_cyc - t0), 32'd8);
        chk("wr3_psel_cycles", 32'(psel_cycles), 32'd7);
        chk("wr3_rdata", resp_data, 32'h0);
        chk("wr3_psel_seen", {28'b0, psel_seen}, 32'h8);
        idle(2);

        // Unmapped read.
        clear_obs(); t0 = cyc;
        do_xfer(32'h0000_8000, 1'b0, 32'h0, 0, 32'h5555_5555, 1'b0, 1'b0, -1);
        chk("miss_latency", 32'(resp_cyc - t0), 32'd2);
        chk("miss_err", {31'b0, resp_err}, 32'd1);
        chk("miss_rdata", resp_data, 32'h0);
        chk("miss_psel_seen", {28'b0, psel_seen}, 32'h0);
        idle(1);

`ifdef APB_DECODE_TIMEOUT_EN
        // Target 2 never ready: abandoned after 8 ACCESS cycles.
        clear_obs(); t0 = cyc;
        do_xfer(32'h0000_2000, 1'b0, 32'h0, 1000, 32'h7777_7777, 1'b0, 1'b0, -1);
        chk("tmo_latency", 32'(resp_cyc - t0), 32'd10);
        chk("tmo_err", {31'b0, resp_err}, 32'd1);
        chk("tmo_rdata", resp_data, 32'h0);
        chk("tmo_psel_cycles", 32'(psel_cycles), 32'd9);
`else
        // Long wait on target 2 completes normally.
        clear_obs(); t0 = cyc;
        do_xfer(32'h0000_2008, 1'b0, 32'h0, 12, 32'h2222_000C, 1'b0, 1'b0, -1);
        chk("long_latency", 32'(resp_cyc - t0), 32'd15);
        chk("long_err", {31'b0, resp_err}, 32'd0);
        chk("long_rdata", resp_data, 32'h2222_000C);
        chk("long_psel_cycles", 32'(psel_cycles), 32'd14);
`endif
        idle(2);

        // Reset during ACCESS to target 0, then a clean read.
        clear_obs();
        do_xfer(32'h0000_0010, 1'b0, 32'h0, 20, 32'h9999_9999, 1'b0, 1'b0, 4);
        chk("abort_no_resp", 32'(resp_cyc), 32'hFFFF_FFFF);
        clear_obs(); t0 = cyc;
        do_xfer(32'h0000_0020, 1'b0, 32'h0, 1, 32'h1234_5678, 1'b0, 1'b0, -1);
        chk("post_rst_latency", 32'(resp_cyc - t0), 32'd4);
        chk("post_rst_rdata", resp_data, 32'h1234_5678);
        idle(1);

        // Overlap: 0x40 matches targets 0 and 2; error from target 0 propagates.
        clear_obs(); t0 = cyc;
        do_xfer(32'h0000_0040, 1'b0, 32'h0, 2, 32'h0BAD_0040, 1'b1, 1'b0, -1);
        chk("ovl_psel_seen", {28'b0, psel_seen}, 32'h1);
        chk("ovl_err", {31'b0, resp_err}, 32'd1);
        chk("ovl_rdata", resp_data, 32'h0BAD_0040);
        chk("ovl_latency", 32'(resp_cyc - t0), 32'd5);
        idle(1);

        // Randomized traffic.
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = (32'($urandom_range(0, 9)) << 12) | ($urandom & 32'hFFF);
            w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(7, 12)) : int'($urandom_range(0, 3));
            do_xfer(a, 1'($urandom), $urandom, w, $urandom, ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 9) == 0), -1);
            idle($urandom_range(0, 2));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
